// File: rtl/seven_sensors_serial_tx_pkg.sv
// Constants and types shared by the sensor-side transmitter and the far-end decoder.
package seven_sensors_serial_tx_pkg;

  localparam int FRAME_BITS      = 10;
  localparam int SENSOR_COUNT    = 7;
  localparam int ALARM_THRESHOLD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Parity bit that makes the total number of ones across data plus parity even.
  function automatic logic even_parity(input logic [SENSOR_COUNT-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/seven_sensors_zero_count.sv
// Combinational count of tripped (zero) sensor lines in a 7-bit snapshot.
module seven_sensors_zero_count
  import seven_sensors_serial_tx_pkg::*;
(
  input  logic [SENSOR_COUNT-1:0] x_i,
  output logic [2:0]              count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < SENSOR_COUNT; i++) begin
      count_o = count_o + {2'b00, ~x_i[i]};
    end
  end

endmodule

// File: rtl/seven_sensors_serial_tx.sv
// Snapshots seven sensor lines and sends them as a start/7-data/even-parity/stop frame,
// keeping a registered zero count and alarm flag for each snapshot.
module seven_sensors_serial_tx
  import seven_sensors_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [SENSOR_COUNT-1:0] X,
  input  logic                    Start,
  output logic                    TxD,
  output logic                    Ready,
  output logic                    Busy,
  output logic                    Done,
  output logic [2:0]              LowCount,
  output logic                    Alarm
);

  localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX   = 3'(SENSOR_COUNT - 1);

  tx_state_t               state_q;
  logic [7:0]              timer_q;
  logic [2:0]              idx_q;
  logic [SENSOR_COUNT-1:0] shift_q;
  logic                    parity_q;
  logic                    txd_q;
  logic                    ready_q;
  logic                    done_q;
  logic [2:0]              low_q;
  logic                    alarm_q;

  logic [2:0]              low_count_d;
  logic                    bit_end_d;
  logic                    capture_d;

  seven_sensors_zero_count u_zero_count (
    .x_i     (X),
    .count_o (low_count_d)
  );

  assign bit_end_d = (timer_q == TIMER_LAST);
  assign capture_d = (state_q == ST_IDLE) && Start;

  // Snapshot and shift path carries no reset; it is always reloaded at capture.
  always_ff @(posedge Clock) begin
    if (capture_d) begin
      shift_q  <= X;
      parity_q <= even_parity(X);
    end else if (state_q == ST_DATA && bit_end_d && idx_q != LAST_IDX) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      low_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      timer_q <= (state_q == ST_IDLE || bit_end_d) ? '0 : timer_q + 8'd1;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          idx_q  <= '0;
          if (Start) begin
            state_q <= ST_START;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            low_q   <= low_count_d;
            alarm_q <= (low_count_d >= 3'(ALARM_THRESHOLD));
          end
        end
        ST_START: begin
          if (bit_end_d) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end_d) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_PARITY;
              txd_q   <= parity_q;
            end else begin
              idx_q <= idx_q + 3'd1;
              txd_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_d) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end_d) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TxD      = txd_q;
  assign Ready    = ready_q;
  assign Busy     = ~ready_q;
  assign Done     = done_q;
  assign LowCount = low_q;
  assign Alarm    = alarm_q;

endmodule

// File: tb/tb_seven_sensors_serial_tx.sv
// Directed plus randomized frames on a CPB=4 and a CPB=1 transmitter, checked against a frame model.
module tb_seven_sensors_serial_tx;

  logic       clk;
  logic       rst4, rst1;
  logic [6:0] x4, x1;
  logic       st4, st1;
  logic       txd4, rdy4, bsy4, dn4, alm4;
  logic       txd1, rdy1, bsy1, dn1, alm1;
  logic [2:0] lc4, lc1;

  bit         sel;
  logic       txd, rdy, bsy, dn, alm;
  logic [2:0] lc;

  int checks   = 0;
  int failures = 0;

  seven_sensors_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .Clock(clk), .Reset(rst4), .X(x4), .Start(st4), .TxD(txd4), .Ready(rdy4),
    .Busy(bsy4), .Done(dn4), .LowCount(lc4), .Alarm(alm4)
  );

  seven_sensors_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .Clock(clk), .Reset(rst1), .X(x1), .Start(st1), .TxD(txd1), .Ready(rdy1),
    .Busy(bsy1), .Done(dn1), .LowCount(lc1), .Alarm(alm1)
  );

  assign txd = sel ? txd1 : txd4;
  assign rdy = sel ? rdy1 : rdy4;
  assign bsy = sel ? bsy1 : bsy4;
  assign dn  = sel ? dn1  : dn4;
  assign alm = sel ? alm1 : alm4;
  assign lc  = sel ? lc1  : lc4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit s, input logic [6:0] xv, input logic stv);
    if (s) begin x1 = xv; st1 = stv; end
    else   begin x4 = xv; st4 = stv; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after an edge with the DUT idle; returns in the Done cycle.
  task automatic send_frame(input bit s, input logic [6:0] xv, input bit hold, input bit noise);
    int cpb;
    int ones;
    logic [9:0] fr;
    sel  = s;
    cpb  = s ? 1 : 4;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(xv[i]);
    fr[0] = 1'b0;
    for (int k = 0; k < 7; k++) fr[k+1] = xv[k];
    fr[8] = (ones % 2) == 1;
    fr[9] = 1'b1;
    set_in(s, xv, 1'b1);
    tick();
    chk("lowcount", 32'(lc), 32'(7 - ones));
    chk("alarm", 32'(alm), 32'((7 - ones) >= 2));
    for (int c = 0; c < 10 * cpb; c++) begin
      chk($sformatf("txd_bit%0d", c / cpb), 32'(txd), 32'(fr[c / cpb]));
      chk("ready_busy", {rdy, bsy, dn}, 32'b010);
      if (noise && c >= cpb && c < 8 * cpb)
        set_in(s, 7'($urandom), 1'($urandom));
      else
        set_in(s, s ? x1 : x4, hold);
      tick();
    end
    chk("done_cycle", {txd, rdy, bsy, dn}, 32'b1101);
    chk("lowcount_hold", 32'(lc), 32'(7 - ones));
    chk("alarm_hold", 32'(alm), 32'((7 - ones) >= 2));
  endtask

  task automatic idle_check(input bit s);
    sel = s;
    set_in(s, s ? x1 : x4, 1'b0);
    tick();
    chk("idle_after", {txd, rdy, bsy, dn}, 32'b1100);
  endtask

  initial begin
    sel = 1'b0;
    rst4 = 1'b1; rst1 = 1'b1;
    x4 = 7'h7F; x1 = 7'h7F;
    st4 = 1'b0; st1 = 1'b0;
    #1;
    chk("reset4", {txd4, rdy4, bsy4, dn4, lc4, alm4}, 32'b1100_000_0);
    chk("reset1", {txd1, rdy1, bsy1, dn1, lc1, alm1}, 32'b1100_000_0);
    tick();
    rst4 = 1'b0; rst1 = 1'b0;
    tick();
    chk("idle4", {txd4, rdy4, dn4}, 32'b110);

    send_frame(0, 7'b1111111, 0, 0);
    idle_check(0);
    send_frame(0, 7'b1111100, 0, 0);
    idle_check(0);
    send_frame(0, 7'b1111110, 0, 0);
    idle_check(0);

    // Start held high across back-to-back frames with alternating X.
    send_frame(0, 7'b1010101, 1, 0);
    send_frame(0, 7'b0101010, 1, 0);
    send_frame(0, 7'b1010101, 0, 0);
    idle_check(0);

    // Start and X disturbed during DATA.
    send_frame(0, 7'b0011011, 0, 1);
    idle_check(0);
    idle_check(0);

    // Asynchronous reset in the middle of a frame.
    sel = 1'b0;
    set_in(0, 7'b0101010, 1'b1);
    tick();
    set_in(0, 7'b0101010, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    rst4 = 1'b1;
    #1;
    chk("midreset", {txd4, rdy4, bsy4, dn4, lc4, alm4}, 32'b1100_000_0);
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    tick();
    chk("post_reset_idle", {txd4, rdy4, dn4}, 32'b110);
    send_frame(0, 7'b1100111, 0, 0);
    idle_check(0);

    send_frame(1, 7'b0000000, 0, 0);
    idle_check(1);
    send_frame(1, 7'b1111111, 1, 0);
    send_frame(1, 7'b0110100, 0, 0);
    idle_check(1);

    for (int r = 0; r < 6; r++) begin
      send_frame(r[0], 7'($urandom), r[1], 0);
      idle_check(r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
